// File: rtl/pong_pkg.sv
// Shared match-state types and constants for the pong scoring path.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY,
        ST_POINT_PAUSE,
        ST_LEVEL_PAUSE,
        ST_GAME_OVER
    } match_state_t;

    typedef logic [1:0] level_t;
    typedef logic [3:0] pts_t;
    typedef logic [1:0] winner_t;

    localparam level_t  MAX_LEVEL   = 2'd3;
    localparam winner_t WINNER_NONE = 2'b00;
    localparam winner_t WINNER_P1   = 2'b01;
    localparam winner_t WINNER_P2   = 2'b10;

    // Leader value widened to 6 bits for the unsigned level-threshold compare.
    function automatic logic [5:0] leader(input pts_t a, input pts_t b);
        return (a > b) ? {2'b00, a} : {2'b00, b};
    endfunction

endpackage

// File: rtl/counter.sv
// Generic up/down event counter with synchronous clear that takes priority over counting.
module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             en,
    input  logic             clear,
    input  logic             up,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= up ? count + 1'b1 : count - 1'b1;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Match-state controller: turns scoring pulses into points, level and serve/pause phases.
module score_keeper
    import pong_pkg::*;
#(
    parameter int unsigned WIN_PTS            = 9,
    parameter int unsigned LEVEL_STEP         = 3,
    parameter int unsigned PAUSE_FRAMES       = 60,
    parameter int unsigned LEVEL_PAUSE_FRAMES = 120
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       finish_frame,
    input  logic       start,
    input  logic       p1_scored,
    input  logic       p2_scored,
    output logic [3:0] pts1,
    output logic [3:0] pts2,
    output logic [1:0] level_state,
    output logic       serve_en,
    output logic       celebrate,
    output logic       game_over,
    output logic [1:0] winner
);

    match_state_t state_q, state_d;
    pts_t         pts1_q, pts1_d;
    pts_t         pts2_q, pts2_d;
    level_t       level_q, level_d;
    winner_t      winner_q, winner_d;
    logic         pause_entry_q, pause_entry_d;
    logic [7:0]   frame_count;
    logic [5:0]   level_thr;
    logic         level_up;
    logic         frame_done;

    assign level_thr = 6'(LEVEL_STEP) * ({4'b0000, level_q} + 6'd1);

    // The first pause cycle holds the counter in clear so its finish_frame is not counted.
    counter #(.WIDTH(8)) u_frame_counter (
        .clock (clock),
        .en    (finish_frame),
        .clear (reset | pause_entry_q),
        .up    (1'b1),
        .count (frame_count)
    );

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        pts1_d        = pts1_q;
        pts2_d        = pts2_q;
        level_d       = level_q;
        winner_d      = winner_q;
        pause_entry_d = 1'b0;
        level_up      = 1'b0;
        frame_done    = finish_frame && !pause_entry_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_PLAY;
            end

            ST_PLAY: begin
                if (p1_scored && p2_scored) begin
                    state_d       = ST_POINT_PAUSE;
                    pause_entry_d = 1'b1;
                end else if (p1_scored || p2_scored) begin
                    if (p1_scored) pts1_d = pts1_q + 4'd1;
                    if (p2_scored) pts2_d = pts2_q + 4'd1;
                    // Level tracks the leader even on the winning point, so the final level is visible.
                    level_up = (leader(pts1_d, pts2_d) >= level_thr) && (level_q != MAX_LEVEL);
                    if (level_up) level_d = level_q + 2'd1;
                    if (pts1_d == pts_t'(WIN_PTS)) begin
                        state_d  = ST_GAME_OVER;
                        winner_d = WINNER_P1;
                    end else if (pts2_d == pts_t'(WIN_PTS)) begin
                        state_d  = ST_GAME_OVER;
                        winner_d = WINNER_P2;
                    end else if (level_up) begin
                        state_d       = ST_LEVEL_PAUSE;
                        pause_entry_d = 1'b1;
                    end else begin
                        state_d       = ST_POINT_PAUSE;
                        pause_entry_d = 1'b1;
                    end
                end
            end

            ST_POINT_PAUSE: begin
                if (frame_done && frame_count == 8'(PAUSE_FRAMES - 1)) state_d = ST_PLAY;
            end

            ST_LEVEL_PAUSE: begin
                if (frame_done && frame_count == 8'(LEVEL_PAUSE_FRAMES - 1)) state_d = ST_PLAY;
            end

            ST_GAME_OVER: begin
                if (start) begin
                    state_d  = ST_IDLE;
                    pts1_d   = '0;
                    pts2_d   = '0;
                    level_d  = '0;
                    winner_d = WINNER_NONE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pts1_q        <= '0;
            pts2_q        <= '0;
            level_q       <= '0;
            winner_q      <= WINNER_NONE;
            pause_entry_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pts1_q        <= pts1_d;
            pts2_q        <= pts2_d;
            level_q       <= level_d;
            winner_q      <= winner_d;
            pause_entry_q <= pause_entry_d;
        end
    end

    assign pts1        = pts1_q;
    assign pts2        = pts2_q;
    assign level_state = level_q;
    assign winner      = winner_q;
    assign serve_en    = (state_q == ST_PLAY);
    assign celebrate   = (state_q == ST_LEVEL_PAUSE);
    assign game_over   = (state_q == ST_GAME_OVER);

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: inputs driven and outputs sampled on the falling edge.
module tb_score_keeper;

    logic       clock = 1'b0;
    logic       reset;
    logic       finish_frame;
    logic       start;
    logic       p1_scored;
    logic       p2_scored;
    logic [3:0] pts1;
    logic [3:0] pts2;
    logic [1:0] level_state;
    logic       serve_en;
    logic       celebrate;
    logic       game_over;
    logic [1:0] winner;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    score_keeper dut (
        .clock        (clock),
        .reset        (reset),
        .finish_frame (finish_frame),
        .start        (start),
        .p1_scored    (p1_scored),
        .p2_scored    (p2_scored),
        .pts1         (pts1),
        .pts2         (pts2),
        .level_state  (level_state),
        .serve_en     (serve_en),
        .celebrate    (celebrate),
        .game_over    (game_over),
        .winner       (winner)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic score(input logic a, input logic b);
        p1_scored = a;
        p2_scored = b;
        @(negedge clock);
        p1_scored = 1'b0;
        p2_scored = 1'b0;
    endtask

    task automatic press_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            finish_frame = 1'b1;
            @(negedge clock);
            finish_frame = 1'b0;
        end
    endtask

    // Skip the entry cycle, then confirm release happens exactly on the n-th frame.
    task automatic finish_pause(input string tag, input int n);
        idle(1);
        frames(n - 1);
        check({tag, "_hold"}, serve_en, 1'b0);
        frames(1);
        check({tag, "_release"}, serve_en, 1'b1);
    endtask

    initial begin
        reset = 1'b1; finish_frame = 1'b0; start = 1'b0;
        p1_scored = 1'b0; p2_scored = 1'b0;
        idle(2);
        reset = 1'b0;
        check("rst_pts1", pts1, 0);
        check("rst_pts2", pts2, 0);
        check("rst_level", level_state, 0);
        check("rst_serve", serve_en, 0);
        check("rst_celebrate", celebrate, 0);
        check("rst_game_over", game_over, 0);
        check("rst_winner", winner, 0);

        score(1, 0);
        check("idle_ignore_p1", pts1, 0);
        check("idle_stays", serve_en, 0);
        press_start();
        check("start_play", serve_en, 1);
        press_start();
        check("play_start_ignored", serve_en, 1);
        check("play_start_pts", pts1, 0);

        // First point and an exact 60-frame pause with stray pulses inside it.
        score(1, 0);
        check("p1_first_pts", pts1, 1);
        check("p1_first_pause", serve_en, 0);
        check("p1_first_no_cel", celebrate, 0);
        idle(1);
        frames(30);
        score(0, 1);
        check("pause_ignore_p2", pts2, 0);
        score(1, 0);
        check("pause_ignore_p1", pts1, 1);
        frames(29);
        check("pause60_hold", serve_en, 0);
        frames(1);
        check("pause60_release", serve_en, 1);

        // Tie rally; also a finish_frame in the entry cycle must not count.
        score(1, 1);
        check("tie_pts1", pts1, 1);
        check("tie_pts2", pts2, 0);
        check("tie_pause", serve_en, 0);
        check("tie_no_cel", celebrate, 0);
        frames(60);
        check("entry_frame_hold", serve_en, 0);
        frames(1);
        check("entry_frame_release", serve_en, 1);

        score(1, 0);
        check("p1_2", pts1, 2);
        finish_pause("p1_2", 60);
        score(1, 0);
        check("p1_3", pts1, 3);
        check("lvl1", level_state, 1);
        check("lvl1_cel", celebrate, 1);
        idle(1);
        frames(119);
        check("lvl1_cel_hold", celebrate, 1);
        frames(1);
        check("lvl1_cel_end", celebrate, 0);
        check("lvl1_serve", serve_en, 1);

        score(1, 0);
        check("p1_4_lvl", level_state, 1);
        finish_pause("p1_4", 60);
        score(1, 0);
        finish_pause("p1_5", 60);
        score(1, 0);
        check("p1_6", pts1, 6);
        check("lvl2", level_state, 2);
        check("lvl2_cel", celebrate, 1);
        finish_pause("lvl2", 120);
        score(1, 0);
        finish_pause("p1_7", 60);
        score(1, 0);
        finish_pause("p1_8", 60);
        score(1, 0);
        check("win_pts1", pts1, 9);
        check("win_game_over", game_over, 1);
        check("win_winner", winner, 1);
        check("win_level", level_state, 3);
        check("win_serve", serve_en, 0);
        score(0, 1);
        check("over_ignore_p2", pts2, 0);
        check("over_held", game_over, 1);
        press_start();
        check("over_start_go", game_over, 0);
        check("over_start_pts1", pts1, 0);
        check("over_start_level", level_state, 0);
        check("over_start_winner", winner, 0);
        check("over_start_idle", serve_en, 0);

        // Second match: p2 leads 3-2 to raise the level, then reset mid-celebration.
        press_start();
        score(0, 1);
        finish_pause("m2_a", 60);
        score(1, 0);
        finish_pause("m2_b", 60);
        score(0, 1);
        finish_pause("m2_c", 60);
        score(1, 0);
        check("m2_pts1", pts1, 2);
        check("m2_lvl0", level_state, 0);
        finish_pause("m2_d", 60);
        score(0, 1);
        check("m2_pts2", pts2, 3);
        check("m2_lvl1", level_state, 1);
        check("m2_cel", celebrate, 1);
        idle(1);
        frames(50);
        reset = 1'b1;
        finish_frame = 1'b1;
        start = 1'b1;
        p1_scored = 1'b1;
        @(negedge clock);
        reset = 1'b0; finish_frame = 1'b0; start = 1'b0; p1_scored = 1'b0;
        check("mid_rst_pts1", pts1, 0);
        check("mid_rst_pts2", pts2, 0);
        check("mid_rst_level", level_state, 0);
        check("mid_rst_cel", celebrate, 0);
        check("mid_rst_serve", serve_en, 0);
        check("mid_rst_over", game_over, 0);
        check("mid_rst_winner", winner, 0);
        score(0, 1);
        check("mid_rst_idle_p2", pts2, 0);
        check("mid_rst_idle_serve", serve_en, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
